// File: rtl/sfifo_rtx.sv
// sfifo_rtx: single-clock FIFO with speculative reads.
// Reads are committed by eop or replayed from the last commit by rewind.
module sfifo_rtx #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             full_n,
    input  logic             rd_en,
    input  logic             eop,
    input  logic             rewind,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             empty_n
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] cmt_ptr_q, cmt_ptr_d;
    logic [CNT_W-1:0]  used_cnt_q, used_cnt_d;
    logic [CNT_W-1:0]  avail_cnt_q, avail_cnt_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;

    logic              wr_acc;
    logic              rd_acc;
    logic              cmt;
    logic [CNT_W-1:0]  wr_inc;
    logic [CNT_W-1:0]  rd_dec;

    function automatic logic [ADDR_W-1:0] next_ptr(
        input logic [ADDR_W-1:0] p
    );
        return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
    endfunction

    always_comb begin
        wr_acc = wr_en & ~full_q;
        rd_acc = rd_en & ~empty_q & ~rewind;
        cmt    = rd_acc & eop;
        wr_inc = wr_acc ? ONE_CNT : '0;
        rd_dec = rd_acc ? ONE_CNT : '0;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
    end

    // Rewind replays everything uncommitted; a commit frees all reads so far.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        cmt_ptr_d   = cmt_ptr_q;
        used_cnt_d  = used_cnt_q + wr_inc;
        avail_cnt_d = avail_cnt_q + wr_inc - rd_dec;
        if (rewind) begin
            rd_ptr_d    = cmt_ptr_q;
            avail_cnt_d = used_cnt_q + wr_inc;
        end else if (cmt) begin
            rd_ptr_d    = next_ptr(rd_ptr_q);
            cmt_ptr_d   = next_ptr(rd_ptr_q);
            used_cnt_d  = avail_cnt_q - ONE_CNT + wr_inc;
            avail_cnt_d = avail_cnt_q - ONE_CNT + wr_inc;
        end else if (rd_acc) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
    end

    always_comb begin
        full_d  = (used_cnt_d == FULL_CNT);
        empty_d = (avail_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmt_ptr_q   <= '0;
            used_cnt_q  <= '0;
            avail_cnt_q <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmt_ptr_q   <= cmt_ptr_d;
            used_cnt_q  <= used_cnt_d;
            avail_cnt_q <= avail_cnt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
        end
    end

    assign full     = full_q;
    assign full_n   = ~full_q;
    assign empty    = empty_q;
    assign empty_n  = ~empty_q;
    assign data_out = mem_q[rd_ptr_q];

    a_avail_le_used: assert property (
        @(posedge clk) disable iff (!rst_n)
        avail_cnt_q <= used_cnt_q
    );

    a_used_le_depth: assert property (
        @(posedge clk) disable iff (!rst_n)
        used_cnt_q <= FULL_CNT
    );

endmodule

// File: tb/tb_sfifo_rtx.sv
// tb_sfifo_rtx: scoreboard bench for sfifo_rtx.
// Model keeps uncommitted entries in a queue plus a speculative read index.
module tb_sfifo_rtx;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             full, full_n;
    logic             rd_en = 1'b0;
    logic             eop = 1'b0;
    logic             rewind = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             empty, empty_n;

    sfifo_rtx #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .data_in(data_in),
        .full(full),
        .full_n(full_n),
        .rd_en(rd_en),
        .eop(eop),
        .rewind(rewind),
        .data_out(data_out),
        .empty(empty),
        .empty_n(empty_n)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem_m[$];
    int               rd_idx = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               vectors = 0;
    int               miscompares = 0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [3:0] exp_flags();
        bit f, em;
        f  = (mem_m.size() == DEPTH);
        em = (mem_m.size() == rd_idx);
        return {f, ~f, em, ~em};
    endfunction

    task automatic model_update(input bit w, input logic [WIDTH-1:0] d,
                                input bit r, input bit e, input bit rw);
        bit fm, em, wa, ra;
        if (!rst_n) begin
            mem_m.delete();
            rd_idx = 0;
            exp_q.delete();
            return;
        end
        fm = (mem_m.size() == DEPTH);
        em = (mem_m.size() == rd_idx);
        wa = w && !fm;
        ra = r && !em && !rw;
        if (rw) rd_idx = 0;
        if (ra) rd_idx++;
        if (ra && e) begin
            for (int i = 0; i < rd_idx; i++) void'(mem_m.pop_front());
            rd_idx = 0;
        end
        if (wa) mem_m.push_back(d);
    endtask

    task automatic step(input bit w, input logic [WIDTH-1:0] d,
                        input bit r, input bit e, input bit rw);
        wr_en = w; data_in = d; rd_en = r; eop = e; rewind = rw;
        if (rst_n && r && !rw && (mem_m.size() > rd_idx))
            exp_q.push_back(mem_m[rd_idx]);
        @(posedge clk);
        #1;
        model_update(w, d, r, e, rw);
    endtask

    // Monitor: flags every cycle, data on each accepted read.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (rst_n === 1'b1) begin
            chk("flags", {28'd0, full, full_n, empty, empty_n},
                {28'd0, exp_flags()});
            if (rd_en && !empty && !rewind) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", {24'd0, data_out}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", {24'd0, data_out}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        int wn, rn;
        bit w, r, e;
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("rst_flags", {28'd0, full, full_n, empty, empty_n}, 32'h6);
        chk("rst_data", {24'd0, data_out}, 32'h0);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("idle_data", {24'd0, data_out}, 32'h0);

        // fill, overflow attempt, drain with commit
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0);
        step(1, 8'h44, 0, 0, 0);
        chk("full_after4", {31'd0, full}, 32'h1);
        step(1, 8'h55, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, (i == 3), 0);
        chk("full_after_cmt", {31'd0, full}, 32'h0);
        chk("empty_after_cmt", {31'd0, empty}, 32'h1);

        // speculative read, rewind, replay
        step(1, 8'hA1, 0, 0, 0);
        step(1, 8'hA2, 0, 0, 0);
        step(1, 8'hA3, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("rew_data", {24'd0, data_out}, 32'hA1);
        chk("rew_empty", {31'd0, empty}, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, (i == 2), 0);
        chk("rew_done_empty", {31'd0, empty}, 32'h1);

        // read everything uncommitted while full
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0);
        step(1, 8'h44, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        chk("spec_empty", {31'd0, empty}, 32'h1);
        chk("spec_full", {31'd0, full}, 32'h1);
        step(1, 8'h66, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("replay_data", {24'd0, data_out}, 32'h11);
        for (int i = 0; i < 4; i++) step(0, 0, 1, (i == 3), 0);

        // rd_en+eop+rewind together
        step(1, 8'hB1, 0, 0, 0);
        step(1, 8'hB2, 0, 0, 0);
        step(1, 8'hB3, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1);
        chk("rew_prio_data", {24'd0, data_out}, 32'hB1);
        chk("rew_prio_full", {31'd0, full}, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, (i == 2), 0);

        // three 3-word packets, concurrent wr/rd across the wrap
        wn = 0;
        rn = 0;
        for (int c = 0; c < 40 && rn < 9; c++) begin
            w = (wn < 9) && (mem_m.size() < DEPTH);
            r = (mem_m.size() > rd_idx);
            e = r && (rn % 3 == 2);
            step(w, 8'(8'hC0 + wn), r, e, 0);
            if (w) wn++;
            if (r) rn++;
        end
        chk("wrap_reads", rn, 9);
        chk("wrap_empty", {31'd0, empty}, 32'h1);

        // reset mid-packet
        step(1, 8'hD1, 0, 0, 0);
        step(1, 8'hD2, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        chk("midrst_flags", {28'd0, full, full_n, empty, empty_n}, 32'h6);
        chk("midrst_data", {24'd0, data_out}, 32'h0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 1), 8'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0));
        end
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
